// File: rtl/uart_mmio_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio_tx_pkg
//  Purpose  : Shared definitions for the memory-mapped UART transmitter:
//             register offsets, status bit positions and TX FSM encodings.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_mmio_tx_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [31:0] UART_DATA_OFS = 32'd0;
  localparam logic [31:0] UART_STAT_OFS = 32'd4;

  // Status word bit positions
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  // TX state machine encodings
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_mmio_tx_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync
//  Purpose  : Single-clock FIFO with occupancy count. A push is accepted only
//             when the FIFO is not full as seen before this edge, so a pop in
//             the same cycle never frees room for the push (no bypass).
//  Ports    : clk, rst_n           clock, async active-low reset
//             push, push_data      write request and data
//             pop, pop_data        read request; pop_data shows the head entry
//             full, empty, count   occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are log2(DEPTH) wide, so the increment wraps modulo depth.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter on the core store path.
//             DATA (BASE+0) pushes a byte into the TX FIFO; STATUS (BASE+4)
//             reads {ovf, empty, full, busy} and any write to it clears ovf.
//  Ports    : clk, rst_n   clock, async active-low reset
//             mem_we       store strobe (SW)
//             mem_addr     store/load address
//             mem_wdata    store data, bits 7:0 used
//             mmio_rdata   status word when addressing STATUS, else 0
//             tx           registered serial output, idle high
//  Revision : 1.0  initial release
// ============================================================================
module uart_mmio_tx
  import uart_mmio_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mmio_rdata,
  output logic        tx
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int            DW       = $clog2(CLKS_PER_BIT);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          data_hit, stat_hit, stat_sel, div_last;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count_unused;
  logic          unused_wdata;

  // Only exact word addresses match, so misaligned stores fall through.
  assign stat_sel     = (mem_addr == BASE_ADDR + UART_STAT_OFS);
  assign data_hit     = mem_we && (mem_addr == BASE_ADDR + UART_DATA_OFS);
  assign stat_hit     = mem_we && stat_sel;
  assign unused_wdata = ^mem_wdata[31:8];

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (data_hit),
    .push_data (mem_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  // Overflow uses the pre-edge full flag, matching the FIFO's no-bypass rule.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_hit)                    ovf_d = 1'b0;
    else if (data_hit && fifo_full) ovf_d = 1'b1;
  end

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          div_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DATA: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_STOP: begin
        if (div_last) begin
          div_d = '0;
          // Chain straight into the next start bit to keep frames contiguous.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is computed from the next state so the registered line changes on
    // the same edge the FSM does.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx = tx_q;

  always_comb begin
    mmio_rdata = '0;
    if (stat_sel) begin
      mmio_rdata[ST_BUSY]  = (state_q != S_IDLE);
      mmio_rdata[ST_FULL]  = fifo_full;
      mmio_rdata[ST_EMPTY] = fifo_empty;
      mmio_rdata[ST_OVF]   = ovf_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mmio_tx
//  Purpose  : Directed self-checking bench for uart_mmio_tx with
//             CLKS_PER_BIT=4 and FIFO_DEPTH=8 (40-cycle frames).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_mmio_tx;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * CPB;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mmio_rdata;
  logic        tx;

  int          n_vec;
  int          n_err;
  logic [7:0]  exp_b [0:9];
  logic [31:0] st;
  int          lows;

  uart_mmio_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mmio_rdata (mmio_rdata),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One store; the write edge is the next rising edge.
  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    @(posedge clk);
    #1;
    mem_we = 1'b0;
  endtask

  task automatic rd_stat(output logic [31:0] v);
    mem_addr = BASE + 32'd4;
    #1;
    v = mmio_rdata;
  endtask

  task automatic do_reset();
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rst_n     = 1'b0;
    #1;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);
  endtask

  // n = 0 is the first cycle of the first start bit. Samples tx mid-bit for
  // nf frames built from exp_b[], then checks the line is idle afterwards.
  task automatic run_frames(input int nf, input int start);
    int          m;
    int          f;
    logic        eb;
    logic [31:0] v;
    for (int n = start; n < nf * FRAME; n++) begin
      if (n >= 0) begin
        m = n % FRAME;
        f = n / FRAME;
        if (m % CPB == CPB / 2) begin
          if (m < CPB)            eb = 1'b0;
          else if (m >= 9 * CPB)  eb = 1'b1;
          else                    eb = exp_b[f][(m - CPB) / CPB];
          chk($sformatf("frame%0d_bit%0d", f, m / CPB), {31'd0, tx}, {31'd0, eb});
        end
        if (n == nf * FRAME - 1) begin
          rd_stat(v);
          chk($sformatf("busy_last_cycle_f%0d", f), {31'd0, v[0]}, 32'd1);
        end
      end
      wait_cyc(1);
    end
    rd_stat(v);
    chk("status_after_frames", v, 32'h4);
    chk("tx_idle_after_frames", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    clk   = 1'b0;
    n_vec = 0;
    n_err = 0;

    // ---------------- reset state
    do_reset();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    rd_stat(st);
    chk("reset_status", st, 32'h4);

    // ---------------- single byte 0x55
    exp_b[0] = 8'h55;
    sw(BASE, 32'h0000_0055);
    chk("single_tx_before_pop", {31'd0, tx}, 32'd1);
    rd_stat(st);
    chk("single_status_queued", st, 32'h0);
    run_frames(1, -1);

    // ---------------- back-to-back three frames
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h3C;
    exp_b[2] = 8'hFF;
    sw(BASE, 32'h0000_00A5);
    sw(BASE, 32'h0000_003C);
    sw(BASE, 32'h0000_00FF);
    run_frames(3, 1);

    // ---------------- overflow: 10 writes, 10th dropped
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exp_b[i] = 8'(8'h3A + 29 * i);
      sw(BASE, {24'hDEAD_BE, exp_b[i]});
    end
    rd_stat(st);
    chk("ovf_status", st, 32'h0B);
    sw(BASE + 32'd4, 32'h0);
    rd_stat(st);
    chk("ovf_cleared_status", st, 32'h03);
    run_frames(9, 9);

    // ---------------- address filter
    sw(BASE + 32'd8, 32'h41);
    sw(BASE + 32'd1, 32'h42);
    mem_we    = 1'b0;
    mem_addr  = BASE;
    mem_wdata = 32'h43;
    wait_cyc(1);
    rd_stat(st);
    chk("filter_status", st, 32'h4);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1) lows++;
      wait_cyc(1);
    end
    chk("filter_tx_low_cycles", 32'(lows), 32'd0);
    mem_addr = BASE + 32'd5;
    #1;
    chk("rdata_misaligned", mmio_rdata, 32'h0);
    mem_addr = BASE;
    #1;
    chk("rdata_data_reg", mmio_rdata, 32'h0);

    // ---------------- full with simultaneous pop on STOP->START
    do_reset();
    for (int i = 0; i < 9; i++) sw(BASE, 32'(8'h60 + i));
    rd_stat(st);
    chk("fill_status", st, 32'h03);
    wait_cyc(32);
    sw(BASE, 32'h77);
    rd_stat(st);
    chk("full_pop_edge_status", st, 32'h09);

    // ---------------- reset mid-frame
    do_reset();
    sw(BASE, 32'hF0);
    sw(BASE, 32'h12);
    sw(BASE, 32'h34);
    wait_cyc(16);
    chk("midframe_bit3_low", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_tx", {31'd0, tx}, 32'd1);
    rd_stat(st);
    chk("midframe_reset_status", st, 32'h4);
    rst_n = 1'b1;
    wait_cyc(1);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1) lows++;
      wait_cyc(1);
    end
    chk("post_reset_tx_low_cycles", 32'(lows), 32'd0);
    rd_stat(st);
    chk("post_reset_status", st, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
